// File: rtl/console_tick_pkg.sv
// Shared types and helpers for the collect-console sample-tick generator.
package console_tick_pkg;

    typedef enum logic [3:0] {
        FSAMP_1KHZ  = 4'h1,
        FSAMP_2KHZ  = 4'h2,
        FSAMP_4KHZ  = 4'h3,
        FSAMP_8KHZ  = 4'h4,
        FSAMP_16KHZ = 4'h5
    } fsamp_t;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        DONE = 3'b100
    } tick_state_t;

    localparam int unsigned HOLD_W = 16;

    // Rate codes 1..5 halve the 1 kHz period per step; anything else runs at 1 kHz.
    function automatic int unsigned period_of(input logic [3:0] code,
                                              input int unsigned clk_div_1k);
        int unsigned p;
        p = clk_div_1k;
        if (code >= FSAMP_1KHZ && code <= FSAMP_16KHZ)
            p = clk_div_1k >> (code - 4'h1);
        return p;
    endfunction

endpackage

// File: rtl/console_tick_chan.sv
// One sample-tick channel: period divider, IDLE/WAIT/DONE FSM, hold timer,
// sticky timeout flag and saturating overrun counter.
module console_tick_chan
    import console_tick_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned CLK_DIV_1K = 50000,
    parameter int unsigned TIMEOUT    = 128,
    parameter int unsigned MISS_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              work,
    input  logic [3:0]        freq_samp,
    input  logic              fd,
    input  logic              err_clr,
    output logic              fs,
    output logic              to_flag,
    output logic [MISS_W-1:0] miss_cnt
);

    tick_state_t       state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  per;
    logic [DIV_W-1:0]  per_next;
    logic [HOLD_W-1:0] hold;
    logic              tick;
    logic              hold_exp;

    assign per_next = DIV_W'(period_of(freq_samp, CLK_DIV_1K));
    assign tick     = (cnt == per - DIV_W'(1));
    assign hold_exp = (hold == HOLD_W'(TIMEOUT - 1));
    assign fs       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            per      <= DIV_W'(CLK_DIV_1K);
            hold     <= '0;
            to_flag  <= 1'b0;
            miss_cnt <= '0;
        end else begin
            if (!work) begin
                state <= IDLE;
                cnt   <= '0;
                hold  <= '0;
                per   <= per_next;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT;
                        cnt   <= '0;
                        hold  <= '0;
                        per   <= per_next;
                    end
                    WAIT: begin
                        if (tick) begin
                            cnt   <= '0;
                            per   <= per_next;
                            hold  <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    DONE: begin
                        cnt <= tick ? '0 : cnt + DIV_W'(1);
                        // A new tick re-arms the strobe; it outranks both ack and timeout.
                        if (tick) begin
                            per  <= per_next;
                            hold <= '0;
                            if (!fd && miss_cnt != '1)
                                miss_cnt <= miss_cnt + MISS_W'(1);
                        end else if (fd) begin
                            state <= WAIT;
                            hold  <= '0;
                        end else if (hold_exp) begin
                            state   <= WAIT;
                            hold    <= '0;
                            to_flag <= 1'b1;
                        end else begin
                            hold <= hold + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        hold  <= '0;
                    end
                endcase
            end
            if (err_clr) begin
                to_flag  <= 1'b0;
                miss_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/console_tick_multi.sv
// NCH independent sample-tick channels sharing run enable and error clear.
module console_tick_multi
    import console_tick_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned CLK_DIV_1K = 50000,
    parameter int unsigned TIMEOUT    = 128,
    parameter int unsigned MISS_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  work,
    input  logic [4*NCH-1:0]      freq_samp,
    input  logic [NCH-1:0]        fd,
    input  logic                  err_clr,
    output logic [NCH-1:0]        fs,
    output logic [NCH-1:0]        to_flag,
    output logic [MISS_W*NCH-1:0] miss_cnt
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        console_tick_chan #(
            .DIV_W      (DIV_W),
            .CLK_DIV_1K (CLK_DIV_1K),
            .TIMEOUT    (TIMEOUT),
            .MISS_W     (MISS_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .work      (work),
            .freq_samp (freq_samp[4*i +: 4]),
            .fd        (fd[i]),
            .err_clr   (err_clr),
            .fs        (fs[i]),
            .to_flag   (to_flag[i]),
            .miss_cnt  (miss_cnt[MISS_W*i +: MISS_W])
        );
    end

endmodule

// File: tb/tb_console_tick_multi.sv
// Self-checking bench for console_tick_multi: rate table, corner sequences, random vs model.
module tb_console_tick_multi;

    localparam int NCH = 4;
    localparam int DIV = 32;
    localparam int TMO = 8;
    localparam int MW  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                work;
    logic [4*NCH-1:0]    freq_samp;
    logic [NCH-1:0]      fd;
    logic                err_clr;
    logic [NCH-1:0]      fs;
    logic [NCH-1:0]      to_flag;
    logic [MW*NCH-1:0]   miss_cnt;

    int tests = 0;
    int fails = 0;

    console_tick_multi #(
        .NCH        (NCH),
        .DIV_W      (16),
        .CLK_DIV_1K (DIV),
        .TIMEOUT    (TMO),
        .MISS_W     (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .work      (work),
        .freq_samp (freq_samp),
        .fd        (fd),
        .err_clr   (err_clr),
        .fs        (fs),
        .to_flag   (to_flag),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    // ---------------- rise-time measurement with immediate ack ----------------
    int first_rise [NCH];
    int second_rise[NCH];

    task automatic measure(input logic [15:0] codes, input int change_edge,
                           input logic [15:0] new_codes);
        logic [NCH-1:0] prev;
        work = 1'b0; fd = '0; freq_samp = codes;
        step(); step();
        for (int c = 0; c < NCH; c++) begin
            first_rise[c] = -1; second_rise[c] = -1;
        end
        prev = '0;
        work = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                if (fs[c] && !prev[c]) begin
                    if (first_rise[c] < 0) first_rise[c] = e;
                    else if (second_rise[c] < 0) second_rise[c] = e;
                end
            end
            prev = fs;
            fd = fs;
            if (e == change_edge) freq_samp = new_codes;
        end
        work = 1'b0; fd = '0;
        step();
    endtask

    // ---------------- reference model (timestamp based) ----------------
    int n_edge;
    bit m_active[NCH];
    bit m_strobe[NCH];
    bit m_flag  [NCH];
    int m_miss  [NCH];
    int m_start [NCH];
    int m_plen  [NCH];
    int m_since [NCH];

    function automatic int rate_period(input int code);
        if (code >= 1 && code <= 5) return DIV / (1 << (code - 1));
        return DIV;
    endfunction

    task automatic model_reset();
        n_edge = 0;
        for (int c = 0; c < NCH; c++) begin
            m_active[c] = 0; m_strobe[c] = 0; m_flag[c] = 0; m_miss[c] = 0;
            m_start[c] = 0; m_plen[c] = DIV; m_since[c] = 0;
        end
    endtask

    task automatic model_step();
        n_edge++;
        for (int c = 0; c < NCH; c++) begin
            int p;
            p = rate_period(int'(freq_samp[4*c +: 4]));
            if (!work) begin
                m_active[c] = 0;
                m_strobe[c] = 0;
            end else if (!m_active[c]) begin
                m_active[c] = 1;
                m_start[c]  = n_edge;
                m_plen[c]   = p;
            end else if (n_edge == m_start[c] + m_plen[c]) begin
                if (m_strobe[c] && !fd[c] && m_miss[c] < (1 << MW) - 1) m_miss[c]++;
                m_strobe[c] = 1;
                m_since[c]  = n_edge;
                m_start[c]  = n_edge;
                m_plen[c]   = p;
            end else if (m_strobe[c] && fd[c]) begin
                m_strobe[c] = 0;
            end else if (m_strobe[c] && n_edge - m_since[c] == TMO) begin
                m_strobe[c] = 0;
                m_flag[c]   = 1;
            end
            if (err_clr) begin
                m_flag[c] = 0;
                m_miss[c] = 0;
            end
        end
    endtask

    typedef struct {
        logic [15:0] codes;
        int          per[NCH];
    } rate_vec_t;

    rate_vec_t vecs[3];

    initial begin
        logic [NCH-1:0]    exp_fs, exp_to;
        logic [MW*NCH-1:0] exp_miss;
        int high_cnt, rise1, rise2;
        logic prev0;

        vecs[0].codes = 16'h5321; vecs[0].per = '{32, 16, 8, 2};
        vecs[1].codes = 16'h6F04; vecs[1].per = '{4, 32, 32, 32};
        vecs[2].codes = 16'h1355; vecs[2].per = '{2, 2, 8, 32};

        rst = 1'b1; work = 1'b0; freq_samp = 16'h1111; fd = '0; err_clr = 1'b0;
        step(); step();
        check("reset_fs", int'(fs), 0);
        check("reset_to_flag", int'(to_flag), 0);
        check("reset_miss", int'(miss_cnt), 0);
        rst = 1'b0;
        step();
        check("post_reset_idle_fs", int'(fs), 0);

        // Rate table: latency P+1 after work, then every P, common start
        foreach (vecs[v]) begin
            measure(vecs[v].codes, -1, vecs[v].codes);
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("rate_v%0d_ch%0d_first", v, c), first_rise[c], vecs[v].per[c] + 1);
                check($sformatf("rate_v%0d_ch%0d_second", v, c), second_rise[c], 2 * vecs[v].per[c] + 1);
            end
        end

        // Mid-period code change 1->2 at cnt=10
        measure(16'h1111, 11, 16'h1112);
        check("switch_first", first_rise[0], 33);
        check("switch_second", second_rise[0], 49);

        // Ack one cycle after fs: each fs pulse is exactly 2 cycles
        work = 1'b0; fd = '0; freq_samp = 16'h1111; step();
        work = 1'b1; prev0 = 1'b0; high_cnt = 0; rise1 = -1; rise2 = -1;
        for (int e = 1; e <= 80; e++) begin
            step();
            if (fs[0] && !prev0) begin
                if (rise1 < 0) rise1 = e; else if (rise2 < 0) rise2 = e;
            end
            if (fs[0] && rise2 < 0) high_cnt++;
            fd[0] = prev0;
            prev0 = fs[0];
        end
        check("delayed_ack_rise1", rise1, 33);
        check("delayed_ack_rise2", rise2, 65);
        check("delayed_ack_high", high_cnt, 2);
        work = 1'b0; fd = '0; step();

        // P=4 with no ack: overruns saturate, no timeout
        pulse_clr();
        freq_samp = 16'h4444; work = 1'b1;
        repeat (80) step();
        check("sat_miss", int'(miss_cnt), 16'hFFFF);
        check("sat_to_flag", int'(to_flag), 0);

        // err_clr coincident with an overrun tick
        work = 1'b0; step(); pulse_clr();
        work = 1'b1;
        repeat (12) step();
        check("clr_pre_miss", int'(miss_cnt), 16'h1111);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        check("clr_same_cycle_miss", int'(miss_cnt), 0);
        repeat (4) step();
        check("clr_next_overrun", int'(miss_cnt), 16'h1111);

        // P=16, no ack: timeout after TIMEOUT cycles high
        work = 1'b0; step(); pulse_clr();
        freq_samp = 16'h2222; work = 1'b1;
        repeat (24) step();
        check("tmo_hold_fs", int'(fs), 4'hF);
        check("tmo_hold_flag", int'(to_flag), 0);
        step();
        check("tmo_fs_low", int'(fs), 0);
        check("tmo_flag_set", int'(to_flag), 4'hF);

        // fd in the same cycle as the timeout: fd wins
        work = 1'b0; step(); pulse_clr();
        work = 1'b1;
        repeat (24) step();
        fd = 4'hF; step(); fd = '0;
        check("fd_tmo_fs", int'(fs), 0);
        check("fd_tmo_flag", int'(to_flag), 0);

        // Drop work while in DONE, then restart; then async reset
        work = 1'b0; step(); pulse_clr();
        freq_samp = 16'h1124; work = 1'b1;
        repeat (30) step();
        check("drop_pre_fs0", int'(fs[0]), 1);
        work = 1'b0; step();
        check("drop_fs", int'(fs), 0);
        check("drop_miss", int'(miss_cnt), 16'h0006);
        check("drop_flag", int'(to_flag), 4'b0010);
        step(); step();
        check("drop_idle_miss", int'(miss_cnt), 16'h0006);
        work = 1'b1;
        repeat (4) step();
        check("restart_fs_early", int'(fs[0]), 0);
        step();
        check("restart_fs_rise", int'(fs[0]), 1);
        repeat (3) step();
        #2 rst = 1'b1; #1;
        check("async_rst_fs", int'(fs), 0);
        check("async_rst_flag", int'(to_flag), 0);
        check("async_rst_miss", int'(miss_cnt), 0);
        work = 1'b0;
        step(); rst = 1'b0; step();

        // Randomized run against the reference model
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            work = ($urandom_range(99) != 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(31) == 0) freq_samp[4*c +: 4] = 4'($urandom_range(15));
                fd[c] = ($urandom_range(3) == 0);
            end
            err_clr = ($urandom_range(149) == 0);
            step();
            model_step();
            for (int c = 0; c < NCH; c++) begin
                exp_fs[c] = m_strobe[c];
                exp_to[c] = m_flag[c];
                exp_miss[MW*c +: MW] = MW'(m_miss[c]);
            end
            check($sformatf("rand_fs_%0d", i), int'(fs), int'(exp_fs));
            check($sformatf("rand_to_%0d", i), int'(to_flag), int'(exp_to));
            check($sformatf("rand_miss_%0d", i), int'(miss_cnt), int'(exp_miss));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
